// File: rtl/data_memory_mc.sv
// data_memory_mc: multi-cycle MEM-stage data memory, stall/done handshake, byte lanes when DMEM_BYTE_EN_EN is defined
module data_memory_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRd,
  input  logic                MemWr,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   Data_out,
  output logic                Stall,
  output logic                Done,
  output logic                Err
);
  localparam int NB = DATA_W / 8;
  localparam int MAX_LAT = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int CW = MAX_LAT > 1 ? $clog2(MAX_LAT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, lat_m1;
  logic go, commit, op_wr, cur_wr;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [DATA_W-1:0] data_q, cur_data;
  logic [NB-1:0] cur_be;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign go = state == IDLE && (MemRd ^ MemWr);
  assign lat_m1 = MemWr ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
  assign commit = state_n == DONE && state != DONE;
  assign cur_wr = state == IDLE ? MemWr : op_wr;
  assign cur_addr = state == IDLE ? Address : addr_q;
  assign cur_data = state == IDLE ? Data_in : data_q;
  assign Stall = go || state == BUSY;
  assign Done = state == DONE;
  assign Err = state == IDLE && MemRd && MemWr;
`ifdef DMEM_BYTE_EN_EN
  logic [NB-1:0] be_q;
  assign cur_be = state == IDLE ? ByteEn : be_q;
  always_ff @(posedge clk)
    if (go) be_q <= ByteEn;
`else
  logic unused_be;
  assign unused_be = ^ByteEn;
  assign cur_be = '1;
`endif
  always_comb begin
    state_n = state;
    state_n = state == DONE ? IDLE
            : state == BUSY ? (cnt == CW'(1) ? DONE : BUSY)
            : go ? (lat_m1 != '0 ? BUSY : DONE) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      Data_out <= '0;
    end else begin
      state <= state_n;
      cnt <= go ? lat_m1 : state == BUSY ? cnt - 1'b1 : cnt;
      if (go) begin
        op_wr <= MemWr;
        addr_q <= Address;
        data_q <= Data_in;
      end
      if (commit && !cur_wr) Data_out <= mem[cur_addr];
    end
  always_ff @(posedge clk)
    if (!rst && commit && cur_wr)
      for (int i = 0; i < NB; i++)
        if (cur_be[i]) mem[cur_addr][8*i +: 8] <= cur_data[8*i +: 8];
endmodule

// File: tb/tb_data_memory_mc.sv
// tb_data_memory_mc: directed table and sequence checks of data_memory_mc
module tb_data_memory_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst, a_rd, a_wr, a_stall, a_done, a_err;
  logic [5:0] a_addr;
  logic [31:0] a_din, a_dout;
  logic [3:0] a_be;
  logic b_rst, b_rd, b_wr, b_stall, b_done, b_err;
  logic [5:0] b_addr;
  logic [31:0] b_din, b_dout;
  logic [3:0] b_be;
  data_memory_mc dut_a (
    .clk(clk), .rst(a_rst), .MemRd(a_rd), .MemWr(a_wr), .Address(a_addr), .Data_in(a_din),
    .ByteEn(a_be), .Data_out(a_dout), .Stall(a_stall), .Done(a_done), .Err(a_err));
  data_memory_mc #(.RD_LAT(4), .WR_LAT(3)) dut_b (
    .clk(clk), .rst(b_rst), .MemRd(b_rd), .MemWr(b_wr), .Address(b_addr), .Data_in(b_din),
    .ByteEn(b_be), .Data_out(b_dout), .Stall(b_stall), .Done(b_done), .Err(b_err));
`ifdef DMEM_BYTE_EN_EN
  localparam logic [31:0] EXP_LANE = 32'h11BB33DD;
  localparam logic [31:0] EXP_BE0 = 32'h1B1B1B1B;
`else
  localparam logic [31:0] EXP_LANE = 32'hAABBCCDD;
  localparam logic [31:0] EXP_BE0 = 32'hFFFFFFFF;
`endif
  typedef struct {
    logic rd, wr;
    logic [5:0] addr;
    logic [31:0] din;
    logic [3:0] be;
    logic stall, done, err, cd;
    logic [31:0] dout;
  } vec_t;
  vec_t v[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic bstep(input logic rd, input logic wr, input logic r, input logic [5:0] ad,
                       input logic [31:0] d, input logic es, input logic ed, input logic cd,
                       input logic [31:0] eo, input string nm);
    b_rd = rd; b_wr = wr; b_rst = r; b_addr = ad; b_din = d;
    @(negedge clk);
    chk({nm, ".stall"}, 32'(b_stall), 32'(es));
    chk({nm, ".done"}, 32'(b_done), 32'(ed));
    chk({nm, ".err"}, 32'(b_err), 32'(0));
    if (cd) chk({nm, ".dout"}, b_dout, eo);
    @(posedge clk); #1;
  endtask
  initial begin
    a_rst = 1; a_rd = 0; a_wr = 0; a_addr = 0; a_din = 0; a_be = 0;
    b_rst = 1; b_rd = 0; b_wr = 0; b_addr = 0; b_din = 0; b_be = 4'hF;
    v.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    v.push_back('{0, 1, 5, 32'hDEADBEEF, 4'hF, 1, 0, 0, 1, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, 0});
    v.push_back('{1, 0, 5, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{1, 0, 9, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF});
    v.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF});
    v.push_back('{0, 1, 3, 32'h11223344, 4'hF, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    v.push_back('{0, 1, 3, 32'hAABBCCDD, 4'h5, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF});
    v.push_back('{1, 0, 3, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_LANE});
    v.push_back('{1, 1, 3, 0, 4'hF, 0, 0, 1, 1, EXP_LANE});
    v.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, EXP_LANE});
    v.push_back('{1, 0, 3, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{1, 1, 3, 0, 4'hF, 1, 0, 0, 0, 0});
    v.push_back('{1, 1, 3, 0, 4'hF, 0, 1, 0, 1, EXP_LANE});
    v.push_back('{0, 1, 0, 32'h0A0A0A0A, 4'hF, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    v.push_back('{0, 1, 1, 32'h1B1B1B1B, 4'hF, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    v.push_back('{1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{1, 0, 1, 0, 0, 0, 1, 0, 1, 32'h0A0A0A0A});
    v.push_back('{1, 0, 1, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h1B1B1B1B});
    v.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1B1B1B1B});
    v.push_back('{0, 1, 1, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    v.push_back('{1, 0, 1, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_BE0});
    repeat (2) @(posedge clk);
    #1 a_rst = 0; b_rst = 0;
    foreach (v[i]) begin
      a_rd = v[i].rd; a_wr = v[i].wr; a_addr = v[i].addr; a_din = v[i].din; a_be = v[i].be;
      @(negedge clk);
      chk($sformatf("a%0d.stall", i), 32'(a_stall), 32'(v[i].stall));
      chk($sformatf("a%0d.done", i), 32'(a_done), 32'(v[i].done));
      chk($sformatf("a%0d.err", i), 32'(a_err), 32'(v[i].err));
      if (v[i].cd) chk($sformatf("a%0d.dout", i), a_dout, v[i].dout);
      @(posedge clk); #1;
    end
    bstep(0, 1, 0, 7, 32'hCAFEF00D, 1, 0, 1, 0, "b_wr0_acc");
    for (int k = 0; k < 2; k++) bstep(0, 0, 0, 0, 0, 1, 0, 0, 0, "b_wr0_busy");
    bstep(0, 0, 0, 0, 0, 0, 1, 0, 0, "b_wr0_done");
    bstep(1, 0, 0, 7, 0, 1, 0, 0, 0, "b_rd0_acc");
    for (int k = 0; k < 3; k++) bstep(0, 0, 0, 0, 0, 1, 0, 0, 0, "b_rd0_busy");
    bstep(0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D, "b_rd0_done");
    bstep(0, 1, 0, 7, 32'h12345678, 1, 0, 0, 0, "b_wr1_acc");
    bstep(0, 0, 0, 0, 0, 1, 0, 0, 0, "b_wr1_busy1");
    bstep(0, 0, 1, 0, 0, 1, 0, 0, 0, "b_wr1_rst");
    bstep(0, 0, 0, 0, 0, 0, 0, 1, 0, "b_after_rst");
    bstep(0, 0, 0, 0, 0, 0, 0, 1, 0, "b_after_rst2");
    bstep(1, 0, 0, 7, 0, 1, 0, 0, 0, "b_rd1_acc");
    for (int k = 0; k < 3; k++) bstep(0, 0, 0, 0, 0, 1, 0, 0, 0, "b_rd1_busy");
    bstep(0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D, "b_rd1_done");
    bstep(1, 0, 1, 7, 0, 1, 0, 0, 0, "b_rst_req");
    bstep(0, 0, 0, 0, 0, 0, 0, 1, 0, "b_rst_req_idle");
    bstep(0, 0, 0, 0, 0, 0, 0, 1, 0, "b_rst_req_idle2");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_memory_mc.md
# data_memory_mc

Parametrised multi-cycle data memory for the MEM stage of the pipeline: the next generation of the single-cycle data memory. It has configurable data width, depth and read/write latency, byte-lane writes, and a stall/done handshake back to the pipeline control. One access is outstanding at a time. The block stalls the pipeline for the access latency and then presents a one-cycle completion window.

## Interface
- DATA_W, 32, data word width in bits; multiple of 8
- ADDR_W, 6, word-address width; depth = 2^ADDR_W words
- RD_LAT, 2, read latency in cycles; ≥1
- WR_LAT, 1, write latency in cycles; ≥1

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- MemRd  in  1  read request
- MemWr  in  1  write request
- Address  in  ADDR_W  word address
- Data_in  in  DATA_W  write data
- ByteEn  in  DATA_W/8  byte-lane write enables; bit i covers Data_in[8i+7:8i]
- Data_out  out  DATA_W  registered read data
- Stall  out  1  pipeline must hold MEM stage
- Done  out  1  access completes this cycle
- Err  out  1  illegal request (MemRd and MemWr both high)

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - MemRd xor MemWr high: latch Address, Data_in, ByteEn and the op.
  - Load the latency counter with LAT−1, where LAT = RD_LAT for a read and WR_LAT for a write.
  - Go to BUSY if LAT > 1, else go to DONE.
- **BUSY**
  - Decrement the counter each cycle; request inputs are ignored.
  - Go to DONE when the counter reaches 0.
- **DONE**
  - Done = 1; request inputs are ignored.
  - Unconditionally return to IDLE.
- **Completion of a read:** on the edge entering DONE, Data_out ← memory[latched address].
- **Completion of a write:** on the same edge, memory lanes with ByteEn=1 take the latched data; other lanes are unchanged.
- **Data_out hold:** Data_out holds its value until the next read completes. Writes never change it.
- **Stall** is combinational: 1 in IDLE when (MemRd|MemWr) and not illegal; 1 throughout BUSY; 0 in DONE and in IDLE with no request.
- **Err:** MemRd & MemWr both high in IDLE gives Err=1 (combinational) that cycle. No access starts, Stall=0, and the state stays IDLE. Both high in BUSY/DONE is ignored.
- **Counter width:** $clog2 of max(RD_LAT, WR_LAT), minimum 1 bit.
- **Storage:** memory contents are not reset and are undefined until written. All addresses are in range by construction.

## Timing
- A request accepted in cycle T (IDLE) gives:
  - Stall = 1 for cycles T … T+LAT−1.
  - Done = 1 in cycle T+LAT.
  - Read data valid on Data_out from cycle T+LAT.
- The pipeline advances at the end of the DONE cycle. The earliest next acceptance is T+LAT+1, so back-to-back accesses have a period of LAT+1.
- **Reset values:** Data_out = 0, Stall = 0 (given no request), Done = 0, Err = 0, state = IDLE, counter = 0.
- **Reset during BUSY or DONE:**
  - The access is aborted and the pending write is discarded; memory is untouched.
  - Data_out = 0.
  - The next cycle is IDLE.
- **Reset and request in the same cycle:** reset wins and no access starts.

## Configuration
- **Macro:** DMEM_BYTE_EN_EN.
- **Defined:** ByteEn is honoured per lane, and a write with ByteEn = 0 completes (Stall/Done as normal) without modifying memory.
- **Undefined:** ByteEn is ignored, and every write updates the full DATA_W word.

## Test plan
- **Reset and idle:** rst high for 2 cycles, then idle → Data_out = 0, Stall = 0, Done = 0, Err = 0.
- **Write then read, defaults:**
  - Stimulus: MemWr, Address = 5, Data_in = 0xDEADBEEF, ByteEn = 0xF. Then, after Done, MemRd at Address = 5.
  - Response: write gives Stall for 1 cycle, then Done. Read gives Stall for 2 cycles, Done in the 3rd cycle, Data_out = 0xDEADBEEF.
- **Byte lanes (macro defined):**
  - Stimulus: Address 3 holds 0x11223344. Write 0xAABBCCDD with ByteEn = 0x5, then read Address 3.
  - Response: Data_out = 0x11BB33DD. With the macro undefined, the same sequence gives 0xAABBCCDD.
- **Illegal request:** MemRd = MemWr = 1 in IDLE → Err = 1 that cycle, Stall = 0, no Done; memory and Data_out unchanged.
- **Reset mid-write:** RD_LAT = 4, WR_LAT = 3, write 0x12345678 to Address 7, assert rst in the second BUSY cycle → no Done, and a later read of Address 7 returns its prior value. With the same parameters, a read shows Stall for 4 cycles and Done in the 5th.
- **Back-to-back:** reads issued to Address 0 and Address 1 as soon as allowed → acceptance cycles are exactly RD_LAT+1 apart. Request inputs changing during BUSY/DONE do not alter the latched address.
